ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard
//   (e.g. 0xED set-LEDs, 0xFF reset) over the bidirectional PS/2 clock/data lines.
//   It sits beside the keyboard scan-code receive path on the same lines. While
//   a transmission is in progress it holds rx_en low so the receiver ignores the
//   line.
// PARAMETERS
//   RTS_CYCLES      5000     clk cycles ps2_clk is held low for request-to-send (100 us @ 50 MHz)
//   TIMEOUT_CYCLES  1000000  max clk cycles from RTS end to final line release (20 ms @ 50 MHz)
//   FILTER_LEN      8        ps2_clk deglitch shift-register length, in samples
// PORTS
//   clk          in     1  system clock
//   reset_n      in     1  asynchronous reset, active low
//   wr_ps2       in     1  start request, one-cycle pulse; sampled only in IDLE
//   din          in     8  byte to send; latched on an accepted wr_ps2
//   ps2_clk      inout  1  PS/2 clock; open-drain: driven 0 or released to 'z'
//   ps2_data     inout  1  PS/2 data; open-drain: driven 0 or released to 'z'
//   tx_idle      out    1  1 = ready to accept wr_ps2
//   tx_done_tick out    1  one-cycle pulse at the end of every accepted transfer
//   tx_ack_err   out    1  valid while tx_done_tick = 1: 1 = no device ACK or timeout
//   rx_en        out    1  equals tx_idle; gates the receiver
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     both lines released; tx_idle=1, rx_en=1, tx_done_tick=0, tx_ack_err=0;
//     state=IDLE. Takes effect immediately, including mid-frame.
//   Line drivers:
//     line = drive_en ? 1'b0 : 1'bz. Both drive_en bits are registered, so the
//     lines are glitch-free.
//   Clock filter:
//     ps2_clk is sampled into a FILTER_LEN shift register. The filtered level
//     goes 1 when the register is all ones and 0 when it is all zeros; otherwise
//     it holds. fall = a 1->0 transition of the filtered level.
//   Frame register:
//     frame[8:0] = {~^din, din} (odd parity). Bits shift out LSB first.
//   FSM:
//     IDLE: lines released. On wr_ps2: latch frame, bit_cnt=0, cyc_cnt=0, go RTS.
//       tx_idle drops on the next cycle.
//     RTS: ps2_clk driven low for exactly RTS_CYCLES cycles, data released. Then
//       go START: release clock, drive data low (start bit), cyc_cnt=0.
//     START: on fall, data = frame[0] (0 -> drive, 1 -> release), go DATA.
//     DATA: on each fall, shift the next frame bit onto data and increment
//       bit_cnt. On the fall following bit 8 (parity), release data (stop bit)
//       and go STOP.
//     STOP: on the next fall (11th), sample ps2_data: ack_ok = (ps2_data==0).
//       Go WAIT_REL.
//     WAIT_REL: when filtered clock = 1 and ps2_data = 1, pulse tx_done_tick
//       with tx_ack_err = ~ack_ok, then go IDLE.
//   Timeout:
//     cyc_cnt counts in START, DATA, STOP and WAIT_REL. When cyc_cnt reaches
//     TIMEOUT_CYCLES: release both lines, pulse tx_done_tick with tx_ack_err=1,
//     go IDLE.
//   Latency and concurrency:
//     Line change lags the filtered edge by 1 cycle; the filter itself adds
//     FILTER_LEN cycles.
//     wr_ps2 outside IDLE is ignored; din is not re-latched.
//     wr_ps2 on the same cycle as tx_done_tick is ignored (tx_idle still 0).
//   Widths:
//     cyc_cnt = $clog2(max(RTS_CYCLES, TIMEOUT_CYCLES)+1) bits; bit_cnt = 4 bits.
// TESTING
//   - din=0xED, device model clocks at 12.5 kHz, samples data on rising edges,
//     ACKs low on clock 11 -> device receives 0xED, parity=1, stop=1;
//     tx_done_tick=1 for one cycle, tx_ack_err=0.
//   - din=0x07, device never ACKs (data high at clock 11) -> parity=0 on the
//     wire; tx_done_tick with tx_ack_err=1.
//   - RTS check: ps2_clk low for exactly 5000 cycles after wr_ps2; rx_en=0 from
//     the cycle after wr_ps2 until after tx_done_tick.
//   - Device silent after RTS -> exactly 1000000 cycles later both lines are 'z'
//     and tx_done_tick fires with tx_ack_err=1.
//   - A 3-sample low glitch on ps2_clk during DATA does not advance the bit.
//     wr_ps2 with din=0xFF mid-frame is ignored; the original byte still
//     completes.
//   - reset_n=0 during DATA bit 4 -> both lines 'z' before the next clk edge;
//     tx_idle=1, no tx_done_tick.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with open-drain line drivers.
// Holds rx_en low for the whole transfer so the scan-code receiver ignores the bus.
module ps2_host_tx #(
   parameter int RTS_CYCLES     = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       tx_ack_err,
   output logic       rx_en
);
   localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAIT_REL} state_t;

   state_t                state;
   logic [FILTER_LEN-1:0] filt;
   logic                  filt_lvl;
   logic                  filt_nxt;
   logic                  fall;
   logic [1:0]            data_sync;
   logic [8:0]            frame;
   logic [3:0]            bit_cnt;
   logic [CW-1:0]         cyc_cnt;
   logic                  drv_clk;
   logic                  drv_data;
   logic                  ack_ok;
   logic                  timeout;

   assign ps2_clk  = drv_clk  ? 1'b0 : 1'bz;
   assign ps2_data = drv_data ? 1'b0 : 1'bz;
   assign rx_en    = tx_idle;

   always_comb begin
      filt_nxt = (&filt) ? 1'b1 : (~|filt) ? 1'b0 : filt_lvl;
      fall     = filt_lvl & ~filt_nxt;
      timeout  = (state inside {START, DATA, STOP, WAIT_REL}) && (cyc_cnt == TO_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         filt         <= '1;
         filt_lvl     <= 1'b1;
         data_sync    <= 2'b11;
         frame        <= '0;
         bit_cnt      <= '0;
         cyc_cnt      <= '0;
         drv_clk      <= 1'b0;
         drv_data     <= 1'b0;
         ack_ok       <= 1'b0;
         tx_idle      <= 1'b1;
         tx_done_tick <= 1'b0;
         tx_ack_err   <= 1'b0;
      end else begin
         filt         <= {filt[FILTER_LEN-2:0], ps2_clk};
         filt_lvl     <= filt_nxt;
         data_sync    <= {data_sync[0], ps2_data};
         tx_done_tick <= 1'b0;
         cyc_cnt      <= cyc_cnt + 1'b1;
         if (timeout) begin
            state        <= IDLE;
            drv_clk      <= 1'b0;
            drv_data     <= 1'b0;
            tx_done_tick <= 1'b1;
            tx_ack_err   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  cyc_cnt <= '0;
                  // tx_idle rises one cycle after done, so a wr_ps2 coincident with done is dropped
                  if (!tx_idle)
                     tx_idle <= 1'b1;
                  else if (wr_ps2) begin
                     frame   <= {~^din, din};
                     bit_cnt <= '0;
                     drv_clk <= 1'b1;
                     tx_idle <= 1'b0;
                     state   <= RTS;
                  end
               end
               RTS: begin
                  if (cyc_cnt == RTS_LAST) begin
                     drv_clk  <= 1'b0;
                     drv_data <= 1'b1;
                     cyc_cnt  <= '0;
                     state    <= START;
                  end
               end
               START: begin
                  if (fall) begin
                     drv_data <= ~frame[0];
                     frame    <= {1'b1, frame[8:1]};
                     bit_cnt  <= 4'd1;
                     state    <= DATA;
                  end
               end
               DATA: begin
                  if (fall) begin
                     if (bit_cnt == 4'd9) begin
                        drv_data <= 1'b0;
                        state    <= STOP;
                     end else begin
                        drv_data <= ~frame[0];
                        frame    <= {1'b1, frame[8:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                     end
                  end
               end
               STOP: begin
                  if (fall) begin
                     ack_ok <= ~data_sync[1];
                     state  <= WAIT_REL;
                  end
               end
               WAIT_REL: begin
                  if (filt_lvl && data_sync[1]) begin
                     tx_done_tick <= 1'b1;
                     tx_ack_err   <= ~ack_ok;
                     state        <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and random host-to-device transfers against a PS/2 device model.
module tb_ps2_host_tx;
   localparam int RTS = 50;
   localparam int TO  = 3000;
   localparam int FL  = 8;
   localparam int HP  = 40;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_ps2 = 1'b0;
   logic [7:0] din = 8'h00;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       tx_idle, tx_done_tick, tx_ack_err, rx_en;
   wire        ps2_clk, ps2_data;
   int         checks = 0;
   int         errors = 0;

   assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   always #5 clk = ~clk;

   ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
      .clk(clk), .reset_n(reset_n), .wr_ps2(wr_ps2), .din(din),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_ack_err(tx_ack_err), .rx_en(rx_en)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_rts(input logic [7:0] b);
      int n;
      din = b;
      wr_ps2 = 1'b1;
      tick;
      wr_ps2 = 1'b0;
      check("rx_en_busy", rx_en, 0);
      check("rts_data_released", ps2_data, 1);
      n = 0;
      while (ps2_clk === 1'b0 && n < 4 * RTS) begin
         n++;
         tick;
      end
      check("rts_len", n, RTS);
      check("start_bit", ps2_data, 0);
   endtask

   // Device clocks the frame; mode 1 adds a clock glitch and a mid-frame wr, mode 2 resets mid-frame.
   task automatic dev_frame(input logic ack, input int mode, output logic [9:0] got, output logic aborted);
      logic seen;
      got = '0;
      aborted = 1'b0;
      repeat (10) tick;
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         repeat (HP / 2) tick;
         if (mode == 2 && k == 5) begin
            #2 reset_n = 1'b0;
            #1;
            check("rst_data_released", ps2_data, 1);
            check("rst_tx_idle", tx_idle, 1);
            check("rst_no_done", tx_done_tick, 0);
            dev_clk_low = 1'b0;
            tick;
            check("rst_clk_released", ps2_clk, 1);
            reset_n = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
               tick;
               seen = seen | tx_done_tick;
            end
            check("rst_done_never", seen, 0);
            check("rst_idle_after", tx_idle, 1);
            aborted = 1'b1;
            return;
         end
         repeat (HP / 2) tick;
         dev_clk_low = 1'b0;
         if (k <= 10) got[k-1] = ps2_data;
         repeat (5) tick;
         if (k == 10 && ack) dev_data_low = 1'b1;
         if (k == 11) dev_data_low = 1'b0;
         if (mode == 1 && k == 4) begin
            dev_clk_low = 1'b1;
            repeat (3) tick;
            dev_clk_low = 1'b0;
         end
         if (mode == 1 && k == 5) begin
            din = 8'hFF;
            wr_ps2 = 1'b1;
            tick;
            wr_ps2 = 1'b0;
            check("busy_ignores_wr", tx_idle, 0);
         end
         if (k < 11) repeat (HP - 10) tick;
      end
   endtask

   task automatic xfer(input logic [7:0] b, input logic ack, input int mode, input logic wr_at_done);
      logic [9:0] got;
      logic       aborted;
      logic       par;
      int         n;
      start_rts(b);
      dev_frame(ack, mode, got, aborted);
      if (aborted) return;
      par = ($countones(b) % 2) == 0;
      check("rx_byte", got[7:0], b);
      check("rx_parity", got[8], par);
      check("rx_stop", got[9], 1);
      n = 0;
      while (tx_done_tick !== 1'b1 && n < 300) begin
         n++;
         tick;
      end
      check("done_pulse", tx_done_tick, 1);
      check("ack_err", tx_ack_err, !ack);
      check("rx_en_at_done", rx_en, 0);
      if (wr_at_done) begin
         din = 8'h55;
         wr_ps2 = 1'b1;
      end
      tick;
      wr_ps2 = 1'b0;
      check("done_width", tx_done_tick, 0);
      check("idle_after_done", tx_idle, 1);
      check("rx_en_after_done", rx_en, 1);
      tick;
      check("wr_at_done_ignored", ps2_clk, 1);
      check("still_idle", tx_idle, 1);
      repeat (20) tick;
   endtask

   initial begin
      logic [7:0] rb;
      logic       ra;
      int         n;
      repeat (3) tick;
      check("reset_idle", tx_idle, 1);
      check("reset_rx_en", rx_en, 1);
      check("reset_done", tx_done_tick, 0);
      check("reset_err", tx_ack_err, 0);
      check("reset_clk_rel", ps2_clk, 1);
      check("reset_data_rel", ps2_data, 1);
      reset_n = 1'b1;
      repeat (20) tick;

      xfer(8'hED, 1'b1, 0, 1'b0);
      xfer(8'h07, 1'b0, 0, 1'b1);
      xfer(8'h3C, 1'b1, 1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         rb = 8'($urandom);
         ra = 1'($urandom_range(0, 1));
         xfer(rb, ra, 0, 1'b0);
      end

      start_rts(8'hA5);
      n = 0;
      while (ps2_data === 1'b0 && n < TO + 100) begin
         n++;
         tick;
      end
      check("timeout_len", n, TO);
      check("timeout_done", tx_done_tick, 1);
      check("timeout_err", tx_ack_err, 1);
      check("timeout_clk_rel", ps2_clk, 1);
      repeat (20) tick;

      xfer(8'h0F, 1'b1, 2, 1'b0);
      repeat (20) tick;
      xfer(8'h5A, 1'b1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
